// File: rtl/muldiv_pkg.sv
// Shared types, width and sign helpers for the multi-cycle multiply/divide unit.
// Pure declarations: no latency and no handshake of their own.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MULT  = 2'b00,
      MULTU = 2'b01,
      DIV   = 2'b10,
      DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   typedef logic [MD_WIDTH-1:0]   word_t;
   typedef logic [2*MD_WIDTH-1:0] dword_t;

   function automatic word_t cneg_w(input word_t v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic dword_t cneg_dw(input dword_t v, input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue, MTHI/MTLO and HI/LO result bundle between the execute stage and the unit.
// The master drives requests; the slave reports busy/done and the HI/LO registers.
interface muldiv_if;
   import muldiv_pkg::*;

   logic  start;
   op_t   op;
   word_t a;
   word_t b;
   logic  hi_we;
   logic  lo_we;
   word_t wdata;
   logic  busy;
   logic  done;
   word_t hi;
   word_t lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU owning HI/LO: WIDTH+1 cycles from issue to result, done pulses after.
// start and MTHI/MTLO are accepted only while idle; requests seen while busy are dropped.
module muldiv_unit
   import muldiv_pkg::*;
(
   input logic     clk,
   input logic     reset,
   muldiv_if.slave bus
);

   localparam int WIDTH = MD_WIDTH;
   localparam int CW    = $clog2(WIDTH) + 1;

   state_t          state_q;
   state_t          state_d;
   op_t             op_q;
   logic            sa_q;
   logic            sb_q;
   logic            done_q;
   logic [CW-1:0]   cnt_q;
   word_t           opd_q;
   word_t           araw_q;
   word_t           hi_q;
   word_t           lo_q;
   dword_t          acc_q;
   dword_t          acc_step;

   logic            is_mul;
   logic            issue_mul;
   logic            issue_signed;
   logic            a_neg;
   logic            b_neg;
   word_t           abs_a;
   word_t           abs_b;
   logic [WIDTH:0]  add_a;
   logic [WIDTH:0]  add_b;
   logic            add_ci;
   logic [WIDTH+1:0] add_s;
   dword_t          prod;
   word_t           fix_hi;
   word_t           fix_lo;

   assign issue_mul    = (bus.op == MULT) || (bus.op == MULTU);
   assign issue_signed = (bus.op == MULT) || (bus.op == DIV);
   assign a_neg        = issue_signed & bus.a[WIDTH-1];
   assign b_neg        = issue_signed & bus.b[WIDTH-1];
   assign abs_a        = cneg_w(bus.a, a_neg);
   assign abs_b        = cneg_w(bus.b, b_neg);
   assign is_mul       = (op_q == MULT) || (op_q == MULTU);

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient};
   // opd holds the multiplicand or divisor. One adder serves both step kinds.
   always_comb begin
      if (is_mul) begin
         add_a  = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
         add_b  = {1'b0, opd_q};
         add_ci = 1'b0;
      end else begin
         add_a  = acc_q[2*WIDTH-1:WIDTH-1];
         add_b  = ~{1'b0, opd_q};
         add_ci = 1'b1;
      end
      add_s = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_ci};

      // In the divide path the carry out means "no borrow": the trial subtract is kept.
      if (is_mul) begin
         if (acc_q[0])
            acc_step = {add_s[WIDTH:0], acc_q[WIDTH-1:1]};
         else
            acc_step = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
      end else begin
         if (add_s[WIDTH+1])
            acc_step = {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      prod   = cneg_dw(acc_q, sa_q ^ sb_q);
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (!is_mul) begin
         if (opd_q == '0) begin
            fix_lo = '1;
            fix_hi = araw_q;
         end else begin
            fix_lo = cneg_w(acc_q[WIDTH-1:0], sa_q ^ sb_q);
            fix_hi = cneg_w(acc_q[2*WIDTH-1:WIDTH], sa_q);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= MULT;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         opd_q   <= '0;
         araw_q  <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == FIX);
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  sa_q   <= a_neg;
                  sb_q   <= b_neg;
                  araw_q <= bus.a;
                  cnt_q  <= '0;
                  opd_q  <= issue_mul ? abs_a : abs_b;
                  acc_q  <= {{WIDTH{1'b0}}, (issue_mul ? abs_b : abs_a)};
               end else begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            RUN: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CW'(1);
            end
            FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
